// File: rtl/pipelined_carry_select_adder_if.sv
// Stream bundle for the pipelined carry-select adder: operand beat in, result beat out.
// The master side drives operands and result backpressure; the slave side is the adder.
interface pipelined_carry_select_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: one SEG_W-bit segment resolved per stage,
// each segment choosing between precomputed carry-0 and carry-1 sums.
module pipelined_carry_select_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipelined_carry_select_adder_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int LAST = NSEG - 1;

    logic             stall;
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The whole pipeline moves in lockstep, so a single stall freezes every stage.
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign advance      = ~stall;
    assign bus.in_ready = ~stall;

    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.cin;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        // Operand bits still waiting for later stages, and result bits resolved so far.
        localparam int REM = WIDTH - (gi + 1) * SEG_W;
        localparam int RES = (gi + 1) * SEG_W;
        localparam int SRC = WIDTH - gi * SEG_W;

        logic [SRC-1:0]   src_a;
        logic [SRC-1:0]   src_b;
        logic             src_v;
        logic             src_c;
        logic [SEG_W:0]   s0;
        logic [SEG_W:0]   s1;
        logic [SEG_W:0]   sel;
        logic [RES-1:0]   res_d;
        logic [RES-1:0]   res_q;
        logic             v_d;
        logic             v_q;
        logic             c_d;
        logic             c_q;

        if (gi == 0) begin : g_head
            assign src_v = bus.in_valid;
            assign src_a = bus.a;
            assign src_b = b_eff;
            assign src_c = cin_eff;

            always_comb begin
                res_d = res_q;
                if (advance) begin
                    res_d = sel[SEG_W-1:0];
                end
            end
        end else begin : g_body
            assign src_v = g_stage[gi-1].v_q;
            assign src_a = g_stage[gi-1].g_fwd.a_q;
            assign src_b = g_stage[gi-1].g_fwd.b_q;
            assign src_c = g_stage[gi-1].c_q;

            always_comb begin
                res_d = res_q;
                if (advance) begin
                    res_d = {sel[SEG_W-1:0], g_stage[gi-1].res_q};
                end
            end
        end

        // Both candidate sums exist before the carry arrives; the carry only drives the mux.
        always_comb begin
            s0  = {1'b0, src_a[SEG_W-1:0]} + {1'b0, src_b[SEG_W-1:0]};
            s1  = {1'b0, src_a[SEG_W-1:0]} + {1'b0, src_b[SEG_W-1:0]}
                + {{SEG_W{1'b0}}, 1'b1};
            sel = src_c ? s1 : s0;
            v_d = advance ? src_v : v_q;
            c_d = advance ? sel[SEG_W] : c_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else begin
                v_q   <= v_d;
                c_q   <= c_d;
                res_q <= res_d;
            end
        end

        if (REM > 0) begin : g_fwd
            logic [REM-1:0] a_d;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_d;
            logic [REM-1:0] b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (advance) begin
                    a_d = src_a[SRC-1:SEG_W];
                    b_d = src_b[SRC-1:SEG_W];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    logic msb_cin;
    logic ovf_d;
    logic ovf_q;
    logic zero_d;
    logic zero_q;

    // Carry into the MSB is recovered from the top segment's MSB sum bit and its operands.
    always_comb begin
        msb_cin = g_stage[LAST].src_a[SEG_W-1] ^ g_stage[LAST].src_b[SEG_W-1]
                ^ g_stage[LAST].sel[SEG_W-1];
        ovf_d   = advance ? (msb_cin ^ g_stage[LAST].sel[SEG_W]) : ovf_q;
        zero_d  = advance ? (g_stage[LAST].src_v & ~|g_stage[LAST].res_d) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out_valid = g_stage[LAST].v_q;
    assign bus.sum       = g_stage[LAST].res_q;
    assign bus.cout      = g_stage[LAST].c_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for the pipelined carry-select adder (WIDTH=16, SEG_W=4).
// Drivers push expected results at acceptance; a forked monitor pops and compares.
module tb_pipelined_carry_select_adder;
    localparam int W    = 16;
    localparam int S    = 4;
    localparam int NSEG = W / S;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;
    logic rand_done;
    exp_t sb[$];
    vec_t vt[10];

    pipelined_carry_select_adder_if #(.WIDTH(W)) dif ();

    pipelined_carry_select_adder #(.WIDTH(W), .SEG_W(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        m;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        m.sum  = full[15:0];
        m.cout = full[16];
        m.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        m.zero = (full[15:0] == 16'h0000);
        return m;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input exp_t e);
        dif.a        = a;
        dif.b        = b;
        dif.cin      = cin;
        dif.sub      = sub;
        dif.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    endtask

    task automatic send_vec(input int i);
        exp_t e;
        e.sum  = vt[i].sum;
        e.cout = vt[i].cout;
        e.ovf  = vt[i].ovf;
        e.zero = vt[i].zero;
        send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e);
    endtask

    task automatic monitor();
        exp_t        e;
        logic        held;
        logic [15:0] h_sum;
        logic        h_c;
        logic        h_o;
        logic        h_z;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", {31'd0, dif.out_valid}, 32'd1);
                    chk("hold_sum", {16'd0, dif.sum}, {16'd0, h_sum});
                    chk("hold_cout", {31'd0, dif.cout}, {31'd0, h_c});
                    chk("hold_ovf", {31'd0, dif.ovf}, {31'd0, h_o});
                    chk("hold_zero", {31'd0, dif.zero}, {31'd0, h_z});
                end
                if (dif.out_valid && dif.out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_result: got sum=%0h expected no beat", dif.sum);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", {16'd0, dif.sum}, {16'd0, e.sum});
                        chk("cout", {31'd0, dif.cout}, {31'd0, e.cout});
                        chk("ovf", {31'd0, dif.ovf}, {31'd0, e.ovf});
                        chk("zero", {31'd0, dif.zero}, {31'd0, e.zero});
                    end
                    held = 1'b0;
                end else if (dif.out_valid) begin
                    held  = 1'b1;
                    h_sum = dif.sum;
                    h_c   = dif.cout;
                    h_o   = dif.ovf;
                    h_z   = dif.zero;
                end else begin
                    held = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            @(posedge clk);
        end
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int   lat;
        logic seen;
        n_vec     = 0;
        n_fail    = 0;
        rand_done = 1'b0;

        //          a        b        cin   sub   sum      cout  ovf   zero
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};
        vt[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vt[8] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vt[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.cin       = 1'b0;
        dif.sub       = 1'b0;
        dif.out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, dif.sum}, 32'd0);
        chk("rst_cout", {31'd0, dif.cout}, 32'd0);
        chk("rst_ovf", {31'd0, dif.ovf}, 32'd0);
        chk("rst_zero", {31'd0, dif.zero}, 32'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);

        // Single beat: latency from the accepting edge
        send_vec(0);
        dif.in_valid = 1'b0;
        lat = 1;
        while (!dif.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, NSEG);
        drain();

        // Directed vectors back-to-back
        for (int i = 1; i < 10; i++) send_vec(i);
        dif.in_valid = 1'b0;
        drain();

        // Five beats with a 3-cycle downstream stall when the first result shows
        fork
            begin
                for (int i = 5; i < 10; i++) send_vec(i);
                dif.in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 50 && !dif.out_valid; t++) begin
                    @(posedge clk);
                    #1;
                end
                dif.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, dif.in_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                dif.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        send_vec(1);
        send_vec(3);
        dif.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk("flush_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, dif.in_ready}, 32'd1);
        seen = 1'b0;
        for (int t = 0; t < NSEG + 2; t++) begin
            @(posedge clk);
            #1;
            seen = seen | dif.out_valid;
        end
        chk("flush_no_result", {31'd0, seen}, 32'd0);

        // Random operands with random source gaps and downstream backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [15:0] ra;
                    logic [15:0] rb;
                    logic        rc;
                    logic        rs;
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
                    if ($urandom_range(0, 3) == 0) begin
                        dif.in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                dif.in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    dif.out_ready = ($urandom_range(0, 3) != 0);
                end
                dif.out_ready = 1'b1;
            end
        join
        drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
